// File: rtl/tdc_pkg.sv
// Shared types and sizing helpers for the TDC code averager.
// Holds the default tap count, the count-width function and the stage-3 state enum.
package tdc_pkg;

  localparam int TAPS_DEFAULT     = 64;
  localparam int AVG_LOG2_DEFAULT = 2;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // A count spans 0..TAPS inclusive, hence one bit more than log2(TAPS).
  function automatic int cnt_width(input int taps);
    return $clog2(taps) + 1;
  endfunction

endpackage

// File: rtl/tdc_thermo_popcount.sv
// Combinational bubble filter and popcount for one captured thermometer vector.
// Also flags a saturated line (every tap set) and a non-monotonic filtered code.
module tdc_thermo_popcount
  import tdc_pkg::*;
#(
  parameter  int TAPS  = TAPS_DEFAULT,
  localparam int CNT_W = cnt_width(TAPS)
) (
  input  logic [TAPS-1:0]  taps,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             err
);

  // Virtual taps: below bit 0 the edge has always passed, above the top it never has.
  logic [TAPS+1:0] ext;
  logic [TAPS-1:0] filt;

  assign ext = {1'b0, taps, 1'b1};

  always_comb begin
    filt = '0;
    for (int i = 0; i < TAPS; i++) begin
      filt[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
  end

  always_comb begin
    cnt = '0;
    err = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      cnt = cnt + CNT_W'(filt[i]);
    end
    for (int i = 0; i < TAPS - 1; i++) begin
      if (!filt[i] && filt[i+1]) begin
        err = 1'b1;
      end
    end
    ovf = (cnt == CNT_W'(TAPS));
  end

endmodule

// File: rtl/tdc_code_averager.sv
// Thermometer-to-count conversion with 2^AVG_LOG2 sample averaging.
// Pipeline: capture register, popcount register, then accumulator FSM with held result registers.
module tdc_code_averager
  import tdc_pkg::*;
#(
  parameter  int TAPS     = TAPS_DEFAULT,
  parameter  int AVG_LOG2 = AVG_LOG2_DEFAULT,
  localparam int CNT_W    = cnt_width(TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             tap_vld,
  input  logic [TAPS-1:0]  taps,
  output logic             out_vld,
  output logic [CNT_W-1:0] out_mean,
  output logic             out_ovf,
  output logic             out_err,
  output logic             busy
);

  // Handshake: tap_vld is a one-cycle strobe with no ready; every strobe not
  // coincident with clear is taken, and out_vld is a one-cycle pulse with no ready.

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int N_W   = AVG_LOG2 + 1;
  localparam logic [N_W-1:0] N_SAMP = N_W'(1 << AVG_LOG2);

  logic             s1_vld_q, s1_vld_d;
  logic [TAPS-1:0]  taps_q, taps_d;
  logic [CNT_W-1:0] pc_cnt;
  logic             pc_ovf, pc_err;
  logic             s2_vld_q, s2_vld_d;
  logic [CNT_W-1:0] s2_cnt_q, s2_cnt_d;
  logic             s2_ovf_q, s2_ovf_d;
  logic             s2_err_q, s2_err_d;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [N_W-1:0]   n_q, n_d;
  logic             stk_ovf_q, stk_ovf_d;
  logic             stk_err_q, stk_err_d;
  logic             out_vld_q, out_vld_d;
  logic [CNT_W-1:0] out_mean_q, out_mean_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_err_q, out_err_d;

  logic [ACC_W-1:0] acc_sum;
  logic [N_W-1:0]   n_sum;
  logic             ovf_sum, err_sum;

  tdc_thermo_popcount #(.TAPS(TAPS)) u_popcount (
    .taps (taps_q),
    .cnt  (pc_cnt),
    .ovf  (pc_ovf),
    .err  (pc_err)
  );

  always_comb begin
    s1_vld_d = tap_vld & ~clear;
    taps_d   = tap_vld ? taps : taps_q;
    s2_vld_d = s1_vld_q & ~clear;
    s2_cnt_d = s1_vld_q ? pc_cnt : s2_cnt_q;
    s2_ovf_d = s1_vld_q ? pc_ovf : s2_ovf_q;
    s2_err_d = s1_vld_q ? pc_err : s2_err_q;
  end

  // In IDLE the incoming sample starts a fresh window; in ACC it extends the current one.
  always_comb begin
    acc_sum = '0;
    n_sum   = '0;
    ovf_sum = 1'b0;
    err_sum = 1'b0;
    case (state_q)
      IDLE: begin
        acc_sum = ACC_W'(s2_cnt_q);
        n_sum   = N_W'(1);
        ovf_sum = s2_ovf_q;
        err_sum = s2_err_q;
      end
      ACC: begin
        acc_sum = acc_q + ACC_W'(s2_cnt_q);
        n_sum   = n_q + N_W'(1);
        ovf_sum = stk_ovf_q | s2_ovf_q;
        err_sum = stk_err_q | s2_err_q;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    n_d        = n_q;
    stk_ovf_d  = stk_ovf_q;
    stk_err_d  = stk_err_q;
    out_vld_d  = 1'b0;
    out_mean_d = out_mean_q;
    out_ovf_d  = out_ovf_q;
    out_err_d  = out_err_q;
    if (clear) begin
      state_d   = IDLE;
      acc_d     = '0;
      n_d       = '0;
      stk_ovf_d = 1'b0;
      stk_err_d = 1'b0;
    end else if (s2_vld_q) begin
      if (n_sum == N_SAMP) begin
        out_vld_d  = 1'b1;
        out_mean_d = CNT_W'(acc_sum >> AVG_LOG2);
        out_ovf_d  = ovf_sum;
        out_err_d  = err_sum;
        state_d    = IDLE;
        acc_d      = '0;
        n_d        = '0;
        stk_ovf_d  = 1'b0;
        stk_err_d  = 1'b0;
      end else begin
        state_d   = ACC;
        acc_d     = acc_sum;
        n_d       = n_sum;
        stk_ovf_d = ovf_sum;
        stk_err_d = err_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      taps_q     <= '0;
      s2_vld_q   <= 1'b0;
      s2_cnt_q   <= '0;
      s2_ovf_q   <= 1'b0;
      s2_err_q   <= 1'b0;
      state_q    <= IDLE;
      acc_q      <= '0;
      n_q        <= '0;
      stk_ovf_q  <= 1'b0;
      stk_err_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_mean_q <= '0;
      out_ovf_q  <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      taps_q     <= taps_d;
      s2_vld_q   <= s2_vld_d;
      s2_cnt_q   <= s2_cnt_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_err_q   <= s2_err_d;
      state_q    <= state_d;
      acc_q      <= acc_d;
      n_q        <= n_d;
      stk_ovf_q  <= stk_ovf_d;
      stk_err_q  <= stk_err_d;
      out_vld_q  <= out_vld_d;
      out_mean_q <= out_mean_d;
      out_ovf_q  <= out_ovf_d;
      out_err_q  <= out_err_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_mean = out_mean_q;
  assign out_ovf  = out_ovf_q;
  assign out_err  = out_err_q;
  assign busy     = (state_q == ACC);

endmodule

// File: tb/tb_tdc_code_averager.sv
// Directed bench for tdc_code_averager: a 4-sample averaging instance and a
// 1-sample instance share the stimulus; results are scoreboarded per instance.
module tb_tdc_code_averager;

  localparam int TAPS  = 64;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             tap_vld;
  logic [TAPS-1:0]  taps;

  logic             out_vld;
  logic [CNT_W-1:0] out_mean;
  logic             out_ovf;
  logic             out_err;
  logic             busy;

  logic             o0_vld;
  logic [CNT_W-1:0] o0_mean;
  logic             o0_ovf;
  logic             o0_err;
  logic             o0_busy;

  always #5 clk = ~clk;

  tdc_code_averager #(.TAPS(TAPS), .AVG_LOG2(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .tap_vld  (tap_vld),
    .taps     (taps),
    .out_vld  (out_vld),
    .out_mean (out_mean),
    .out_ovf  (out_ovf),
    .out_err  (out_err),
    .busy     (busy)
  );

  tdc_code_averager #(.TAPS(TAPS), .AVG_LOG2(0)) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .tap_vld  (tap_vld),
    .taps     (taps),
    .out_vld  (o0_vld),
    .out_mean (o0_mean),
    .out_ovf  (o0_ovf),
    .out_err  (o0_err),
    .busy     (o0_busy)
  );

  typedef struct {
    logic [TAPS-1:0]  taps;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             err;
  } pat_t;

  typedef struct {
    int               p0, p1, p2, p3;
    logic [CNT_W-1:0] mean;
    logic             ovf;
    logic             err;
  } win_t;

  pat_t pats[14];
  win_t wins[10];

  logic [CNT_W+1:0] exp_q[$];
  logic [CNT_W+1:0] exp0_q[$];
  logic [CNT_W+1:0] e_main, e_one;

  int checks   = 0;
  int failures = 0;

  // Scoreboards: each result pulse is checked against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL avg4_unexpected_vld got mean=%0d ovf=%0d err=%0d", out_mean, out_ovf, out_err);
      end else begin
        e_main = exp_q.pop_front();
        if ({out_mean, out_ovf, out_err} !== e_main) begin
          failures++;
          $display("FAIL avg4_result got mean=%0d ovf=%0d err=%0d exp mean=%0d ovf=%0d err=%0d",
                   out_mean, out_ovf, out_err, e_main[CNT_W+1:2], e_main[1], e_main[0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && o0_vld) begin
      checks++;
      if (exp0_q.size() == 0) begin
        failures++;
        $display("FAIL avg1_unexpected_vld got mean=%0d", o0_mean);
      end else begin
        e_one = exp0_q.pop_front();
        if ({o0_mean, o0_ovf, o0_err} !== e_one) begin
          failures++;
          $display("FAIL avg1_result got mean=%0d ovf=%0d err=%0d exp mean=%0d ovf=%0d err=%0d",
                   o0_mean, o0_ovf, o0_err, e_one[CNT_W+1:2], e_one[1], e_one[0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, expv);
    end
  endtask

  task automatic set_pat(input int i, input logic [TAPS-1:0] t, input int c, input logic o, input logic e);
    pats[i].taps = t;
    pats[i].cnt  = CNT_W'(c);
    pats[i].ovf  = o;
    pats[i].err  = e;
  endtask

  task automatic set_win(input int i, input int a, input int b, input int c, input int d,
                         input int m, input logic o, input logic e);
    wins[i].p0   = a;
    wins[i].p1   = b;
    wins[i].p2   = c;
    wins[i].p3   = d;
    wins[i].mean = CNT_W'(m);
    wins[i].ovf  = o;
    wins[i].err  = e;
  endtask

  task automatic strobe(input int pi, input logic clr);
    @(negedge clk);
    tap_vld = 1'b1;
    taps    = pats[pi].taps;
    clear   = clr;
    if (!clr) exp0_q.push_back({pats[pi].cnt, pats[pi].ovf, pats[pi].err});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tap_vld = 1'b0;
      clear   = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle(1);
    while ((exp_q.size() != 0 || exp0_q.size() != 0) && n < 20) begin
      idle(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || exp0_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending avg4=%0d avg1=%0d exp 0/0", exp_q.size(), exp0_q.size());
      exp_q.delete();
      exp0_q.delete();
    end
    idle(3);
  endtask

  task automatic run_win(input int w);
    exp_q.push_back({wins[w].mean, wins[w].ovf, wins[w].err});
    strobe(wins[w].p0, 1'b0);
    strobe(wins[w].p1, 1'b0);
    strobe(wins[w].p2, 1'b0);
    strobe(wins[w].p3, 1'b0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_pat(0,  64'h0000_0000_000F_FFFF, 20, 1'b0, 1'b0);
    set_pat(1,  64'h0000_0000_000F_FBFF, 20, 1'b0, 1'b0);
    set_pat(2,  64'h0000_0000_0003_FFFF, 18, 1'b0, 1'b0);
    set_pat(3,  64'h0000_0000_003F_FFFF, 22, 1'b0, 1'b0);
    set_pat(4,  64'h0000_0000_00FF_FFFF, 24, 1'b0, 1'b0);
    set_pat(5,  64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1, 1'b0);
    set_pat(6,  64'h0000_00FF_C000_03FF, 20, 1'b0, 1'b1);
    set_pat(7,  64'h0000_0000_0000_0000, 0,  1'b0, 1'b0);
    set_pat(8,  64'h0000_0000_0000_0001, 1,  1'b0, 1'b0);
    set_pat(9,  64'h0000_0000_0000_0003, 2,  1'b0, 1'b0);
    set_pat(10, 64'h0000_0000_0000_00FF, 8,  1'b0, 1'b0);
    set_pat(11, 64'h0000_0000_3FFF_FFFF, 30, 1'b0, 1'b0);
    set_pat(12, 64'h0000_0000_0000_0002, 1,  1'b0, 1'b0);
    set_pat(13, 64'h7FFF_FFFF_FFFF_FFFF, 63, 1'b0, 1'b0);

    set_win(0, 0, 0, 0, 0,    20, 1'b0, 1'b0);
    set_win(1, 1, 1, 1, 1,    20, 1'b0, 1'b0);
    set_win(2, 2, 0, 3, 4,    21, 1'b0, 1'b0);
    set_win(3, 5, 0, 0, 0,    31, 1'b1, 1'b0);
    set_win(4, 0, 0, 0, 0,    20, 1'b0, 1'b0);
    set_win(5, 6, 0, 0, 0,    20, 1'b0, 1'b1);
    set_win(6, 7, 7, 7, 7,    0,  1'b0, 1'b0);
    set_win(7, 8, 8, 8, 9,    1,  1'b0, 1'b0);
    set_win(8, 12, 13, 13, 13, 47, 1'b0, 1'b0);
    set_win(9, 5, 5, 5, 5,    64, 1'b1, 1'b0);

    rst_n   = 1'b0;
    clear   = 1'b0;
    tap_vld = 1'b0;
    taps    = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {23'd0, out_vld, out_mean, out_ovf, out_err, busy}, 32'd0);
    chk("reset_outputs_avg1", {23'd0, o0_vld, o0_mean, o0_ovf, o0_err, o0_busy}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // First window by hand: result pulse lands exactly three cycles after the last strobe.
    exp_q.push_back({wins[0].mean, wins[0].ovf, wins[0].err});
    chk("busy_idle_before", {31'd0, busy}, 32'd0);
    strobe(0, 1'b0);
    strobe(0, 1'b0);
    strobe(0, 1'b0);
    strobe(0, 1'b0);
    idle(1);
    chk("lat_edge1_vld", {31'd0, out_vld}, 32'd0);
    chk("lat_edge1_busy", {31'd0, busy}, 32'd1);
    idle(1);
    chk("lat_edge2_vld", {31'd0, out_vld}, 32'd0);
    idle(1);
    chk("lat_edge3_vld", {31'd0, out_vld}, 32'd1);
    chk("lat_edge3_busy", {31'd0, busy}, 32'd0);
    drain();
    chk("vld_single_pulse", {31'd0, out_vld}, 32'd0);

    for (int w = 1; w < 10; w++) begin
      run_win(w);
      chk("held_mean_after_win", {25'd0, out_mean}, {25'd0, wins[w].mean});
    end

    // Abort a half-filled window; held outputs survive the clear.
    strobe(0, 1'b0);
    strobe(0, 1'b0);
    drain();
    chk("clear_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    tap_vld = 1'b0;
    clear   = 1'b1;
    idle(1);
    chk("clear_busy_after", {31'd0, busy}, 32'd0);
    chk("clear_held_mean", {25'd0, out_mean}, 32'd64);
    chk("clear_held_ovf", {31'd0, out_ovf}, 32'd1);
    run_win(0);
    exp_q.delete();
    exp_q.push_back({7'd8, 1'b0, 1'b0});
    strobe(10, 1'b0);
    strobe(10, 1'b0);
    strobe(10, 1'b0);
    strobe(10, 1'b0);
    drain();

    // A sample coincident with clear must be dropped, not counted.
    exp_q.push_back({7'd8, 1'b0, 1'b0});
    strobe(11, 1'b1);
    strobe(10, 1'b0);
    strobe(10, 1'b0);
    strobe(10, 1'b0);
    strobe(10, 1'b0);
    drain();

    // Asynchronous reset between edges in the middle of a window.
    strobe(5, 1'b0);
    strobe(5, 1'b0);
    drain();
    chk("rst_busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_mean", {25'd0, out_mean}, 32'd0);
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_avg1_mean", {25'd0, o0_mean}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    exp_q.push_back({7'd8, 1'b0, 1'b0});
    strobe(10, 1'b0);
    strobe(10, 1'b0);
    idle(4);
    chk("rst_no_partial_vld", {31'd0, out_vld}, 32'd0);
    strobe(10, 1'b0);
    strobe(10, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdc_code_averager.md
# tdc_code_averager

Post-processing stage directly downstream of the delay-line sampler in the TDC tile. Takes each captured thermometer tap vector, removes single-tap bubbles, converts it to a binary fine-time count, and averages 2^AVG_LOG2 consecutive measurements into one result with a valid pulse. Results feed the 8-bit dedicated output mux.

## Interface
- TAPS, 64, number of delay-line taps; power of two, 8..128
- AVG_LOG2, 2, log2 of samples per averaged result; 0..4
- CNT_W, $clog2(TAPS)+1, width of a single count (derived; not overridable)
- clk  in  1  single system clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous abort: discards the partial accumulation
- tap_vld  in  1  one-cycle strobe: taps holds a new capture
- taps  in  TAPS  thermometer vector, bit 0 nearest the start edge
- out_vld  out  1  one-cycle pulse: outputs below updated
- out_mean  out  CNT_W  floor(sum / 2^AVG_LOG2)
- out_ovf  out  1  at least one sample in the window had every tap set
- out_err  out  1  at least one filtered sample in the window was non-monotonic
- busy  out  1  accumulation window in progress

## Operation
- Stage 1 (register on tap_vld): bubble filter f[i] = maj(t[i-1], t[i], t[i+1]), with t[-1]=1, t[TAPS]=0.
- Stage 2: cnt = popcount(f), range 0..TAPS; ovf_s = (cnt == TAPS); err_s = any i with f[i]=0 and f[i+1]=1.
- Stage 3 FSM, states IDLE, ACC:
  - IDLE: busy=0; stage-2 valid -> acc=cnt, n=1, sticky flags = sample flags; go ACC (or emit result immediately if AVG_LOG2=0, stay IDLE).
  - ACC: busy=1; each stage-2 valid adds cnt, ORs flags, n++; when n reaches 2^AVG_LOG2 -> register out_mean=acc_total>>AVG_LOG2, out_ovf, out_err, pulse out_vld, return IDLE.
- Accumulator width CNT_W+AVG_LOG2; cannot overflow (max TAPS·2^AVG_LOG2). Truncating shift, no rounding.
- out_mean/out_ovf/out_err hold until next result.
- clear: flushes stage-1/2 valids and accumulator, FSM -> IDLE, no out_vld that cycle; held outputs unchanged. clear and tap_vld in the same cycle: clear wins, sample dropped.
- tap_vld is accepted every cycle (no backpressure); back-to-back strobes all counted.
- Reset mid-window: all state cleared; no partial result is ever emitted.

## Timing
- Reset values: out_vld=0, out_mean=0, out_ovf=0, out_err=0, busy=0; FSM IDLE, pipeline valids 0.
- Latency: tap_vld sampled at edge E -> count valid after E+1 -> accumulation/result at E+2; out_vld high during the cycle after E+2 for the window-completing sample.
- busy rises the cycle after the first sample's accumulation edge; falls with out_vld.
- Throughput: one sample per clock; one result per 2^AVG_LOG2 samples.

## Structure
- Package tdc_pkg: TAPS default, CNT_W function, state enum {IDLE, ACC}.
- Sub-module tdc_thermo_popcount: combinational bubble filter + popcount + ovf/err flags; instantiated between stage-1 and stage-2 registers.
- FSM, accumulator, sample counter, result registers in the top of this block.

## Test plan
- TAPS=64, AVG_LOG2=2: four strobes with taps=0x000F_FFFF (20 ones) -> one out_vld, out_mean=20, ovf=0, err=0, 3-cycle latency from last strobe.
- Bubble: taps=0x000F_FBFF (bit 10 cleared) ×4 -> out_mean=20, err=0; counts 18,20,22,24 -> out_mean=21.
- Overflow: one of four samples all ones -> out_ovf=1, mean includes count 64; next clean window -> out_ovf=0.
- Non-monotonic: taps bits 0-9 and 30-39 set -> out_err=1 for that window only.
- clear after 2 of 4 samples, then 4 samples of count 8 -> exactly one out_vld, out_mean=8; clear coincident with tap_vld drops that sample.
- rst_n asserted mid-window (async, between edges) -> outputs 0 immediately, no out_vld; AVG_LOG2=0 build: every strobe yields out_vld.
